// File: rtl/definitions_pkg.sv
// Shared rv32i memory-stage definitions: bus word type, LSU states,
// fault codes and funct3 access-size encodings.
package definitions_pkg;

    typedef logic [31:0] word_st;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        FAULT_OK         = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_ILLEGAL    = 2'b10,
        FAULT_TIMEOUT    = 2'b11
    } lsu_fault_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: enables, store replication,
// access legality checks and right-justification of load data.
module lsu_lane_align
    import definitions_pkg::*;
(
    input  logic       we_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] off_i,
    input  word_st     wdata_i,
    input  logic [1:0] ld_off_i,
    input  word_st     rdata_i,
    output logic [3:0] be_o,
    output word_st     wdata_o,
    output logic       misaligned_o,
    output logic       illegal_o,
    output word_st     rdata_o
);

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        unique case (funct3_i)
            F3_B, F3_BU: begin
                be_o      = 4'b0001 << off_i;
                wdata_o   = {4{wdata_i[7:0]}};
                // unsigned variants have no meaning for stores
                illegal_o = we_i && (funct3_i == F3_BU);
            end
            F3_H, F3_HU: begin
                be_o         = 4'b0011 << off_i;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = off_i[0];
                illegal_o    = we_i && (funct3_i == F3_HU);
            end
            F3_W: begin
                be_o         = 4'b1111;
                misaligned_o = (off_i != 2'b00);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    assign rdata_o = rdata_i >> {ld_off_i, 3'b000};

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one request at a time over a
// req/gnt/rvalid word bus, with misalign, illegal and timeout faults.
module lsu_bus_ctrl
    import definitions_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  word_st      wdata_i,
    output logic        rsp_valid_o,
    output word_st      rdata_o,
    output logic [1:0]  fault_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output word_st      bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  word_st      bus_rdata_i
);

    localparam logic [15:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e   state_q, state_d;
    lsu_fault_e   fault_q, fault_d;
    logic         we_q, we_d;
    logic [1:0]   off_q, off_d;
    logic [29:0]  addr_q, addr_d;
    logic [3:0]   be_q, be_d;
    word_st       wdata_q, wdata_d;
    word_st       rdata_q, rdata_d;
    logic [15:0]  cnt_q, cnt_d;

    logic [3:0]   lane_be;
    word_st       lane_wdata;
    word_st       lane_rdata;
    logic         lane_mis;
    logic         lane_ill;
    logic         to_hit;

    lsu_lane_align u_lane (
        .we_i         (we_i),
        .funct3_i     (funct3_i),
        .off_i        (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .ld_off_i     (off_q),
        .rdata_i      (bus_rdata_i),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .misaligned_o (lane_mis),
        .illegal_o    (lane_ill),
        .rdata_o      (lane_rdata)
    );

    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        we_d    = we_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = we_i;
                    off_d   = addr_i[1:0];
                    addr_d  = addr_i[31:2];
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (lane_ill) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = RESP;
                    end else if (lane_mis) begin
                        fault_d = FAULT_MISALIGNED;
                        state_d = RESP;
                    end else begin
                        fault_d = FAULT_OK;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                // a granted store has already committed on the bus
                if (bus_gnt_i && we_q) begin
                    state_d = RESP;
                end else if (to_hit) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = RESP;
                end else if (bus_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (bus_rvalid_i) begin
                    rdata_d = lane_rdata;
                    state_d = RESP;
                end else if (to_hit) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            fault_q <= FAULT_OK;
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            we_q    <= we_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign bus_req_o   = (state_q == REQ);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = {addr_q, 2'b00};
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed self-checking bench for lsu_bus_ctrl with an 8-cycle
// timeout so the abort path is reached quickly.
module tb_lsu_bus_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic [1:0]  fault_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .we_i         (we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rdata_o      (rdata_o),
        .fault_o      (fault_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // called at a negedge; the request is accepted at the next posedge
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid_i = 1'b1;
        we_i        = we;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        @(posedge clk_i);
    endtask

    // latency counts the accept cycle as 1; ends at the negedge where
    // rsp_valid_o is high so the caller can check the response there
    task automatic wait_rsp(input int n0, output int n);
        n = n0;
        repeat (40) begin
            @(negedge clk_i);
            n++;
            if (n == 2) begin
                req_valid_i = 1'b0;
                s_req  = bus_req_o;
                s_we   = bus_we_o;
                s_addr = bus_addr_o;
                s_be   = bus_be_o;
                s_wd   = bus_wdata_o;
            end
            if (rsp_valid_o) break;
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        we_i         = 1'b0;
        funct3_i     = 3'b000;
        addr_i       = '0;
        wdata_i      = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        repeat (2) @(negedge clk_i);

        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp", 32'(rsp_valid_o), 32'd0);
        chk("rst_busreq", 32'(bus_req_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_be", 32'(bus_be_o), 32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // LBU at 0x1003, zero-wait bus
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hAABBCCDD;
        issue(1'b0, 3'b100, 32'h0000_1003, 32'd0);
        wait_rsp(1, lat);
        chk("lbu_req", 32'(s_req), 32'd1);
        chk("lbu_addr", s_addr, 32'h0000_1000);
        chk("lbu_be", 32'(s_be), 32'b1000);
        chk("lbu_lat", 32'(lat), 32'd4);
        chk("lbu_rdata", rdata_o, 32'h0000_00AA);
        chk("lbu_fault", 32'(fault_o), 32'd0);
        @(negedge clk_i);
        chk("lbu_pulse", 32'(rsp_valid_o), 32'd0);
        chk("lbu_ready", 32'(req_ready_o), 32'd1);

        // SH at 0x2002
        bus_rvalid_i = 1'b0;
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234);
        wait_rsp(1, lat);
        chk("sh_we", 32'(s_we), 32'd1);
        chk("sh_be", 32'(s_be), 32'b1100);
        chk("sh_wdata", s_wd, 32'h1234_1234);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_rdata", rdata_o, 32'd0);
        chk("sh_fault", 32'(fault_o), 32'd0);
        @(negedge clk_i);

        // SB at 0x0005
        issue(1'b1, 3'b000, 32'h0000_0005, 32'h0000_55AB);
        wait_rsp(1, lat);
        chk("sb_be", 32'(s_be), 32'b0010);
        chk("sb_wdata", s_wd, 32'hABAB_ABAB);
        chk("sb_lat", 32'(lat), 32'd3);
        @(negedge clk_i);

        // misaligned LW, then illegal funct3 codes
        issue(1'b0, 3'b010, 32'h0000_0001, 32'd0);
        wait_rsp(1, lat);
        chk("mis_busreq", 32'(s_req), 32'd0);
        chk("mis_lat", 32'(lat), 32'd2);
        chk("mis_fault", 32'(fault_o), 32'b01);
        chk("mis_rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        issue(1'b0, 3'b011, 32'h0000_0000, 32'd0);
        wait_rsp(1, lat);
        chk("ill_busreq", 32'(s_req), 32'd0);
        chk("ill_lat", 32'(lat), 32'd2);
        chk("ill_fault", 32'(fault_o), 32'b10);
        @(negedge clk_i);
        issue(1'b1, 3'b100, 32'h0000_0000, 32'd0);
        wait_rsp(1, lat);
        chk("sbu_fault", 32'(fault_o), 32'b10);
        @(negedge clk_i);

        // LW with grant withheld for three REQ cycles
        bus_gnt_i = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_3000, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            chk("hold_req", 32'(bus_req_o), 32'd1);
            chk("hold_addr", bus_addr_o, 32'h0000_3000);
            chk("hold_be", 32'(bus_be_o), 32'b1111);
            chk("hold_ready", 32'(req_ready_o), 32'd0);
        end
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1122_3344;
        wait_rsp(4, lat);
        chk("hold_lat", 32'(lat), 32'd6);
        chk("hold_rdata", rdata_o, 32'h1122_3344);
        chk("hold_fault", 32'(fault_o), 32'd0);
        @(negedge clk_i);

        // timeout: granted load never returns data
        bus_rvalid_i = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0040, 32'd0);
        wait_rsp(1, lat);
        chk("to_lat", 32'(lat), 32'd10);
        chk("to_fault", 32'(fault_o), 32'b11);
        chk("to_rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        chk("to_idle", 32'(req_ready_o), 32'd1);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h5555_5555;
        @(negedge clk_i);
        bus_rvalid_i = 1'b0;
        chk("late_rv_rsp", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
        chk("late_rv_rsp2", 32'(rsp_valid_o), 32'd0);

        // reset while waiting for read data
        issue(1'b0, 3'b010, 32'h0000_0080, 32'd0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_busreq", 32'(bus_req_o), 32'd0);
        chk("pre_rst_ready", 32'(req_ready_o), 32'd0);
        #1 rst_ni = 1'b0;
        #1;
        chk("mid_rst_busreq", 32'(bus_req_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_addr", bus_addr_o, 32'd0);
        chk("mid_rst_rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        rst_ni       = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("post_rst_rsp", 32'(rsp_valid_o), 32'd0);
        end
        bus_rdata_i = 32'hCAFE_F00D;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'd0);
        wait_rsp(1, lat);
        chk("lw10_addr", s_addr, 32'h0000_0010);
        chk("lw10_lat", 32'(lat), 32'd4);
        chk("lw10_rdata", rdata_o, 32'hCAFE_F00D);
        chk("lw10_fault", 32'(fault_o), 32'd0);
        @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store bus controller sitting directly upstream of the load-data extender in the rv32i memory stage. It accepts one load/store request from the pipeline and drives a word-addressed data bus with a request/grant/rvalid handshake. It generates byte enables and replicated store data, and detects misaligned and illegal accesses. For loads it returns the addressed bytes right-justified at bit 0, unextended, ready for sizing and extension downstream.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in REQ+WAIT before aborting with a timeout fault; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  pipeline request valid
req_ready_o  out  1  controller can accept a request (IDLE only)
we_i  in  1  1 = store, 0 = load
funct3_i  in  3  access size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr_i  in  32  byte address
wdata_i  in  word_st  store data, right-justified
rsp_valid_o  out  1  one-cycle response pulse
rdata_o  out  word_st  load data shifted right by byte offset; 0 for stores and faults
fault_o  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write
bus_addr_o  out  32  word address, {addr[31:2],2'b00}
bus_be_o  out  4  byte enables
bus_wdata_o  out  word_st  lane-replicated store data
bus_gnt_i  in  1  bus grant
bus_rvalid_i  in  1  read data valid
bus_rdata_i  in  word_st  read data

Behaviour:
- Clock is clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: FSM IDLE; req_ready_o=1; rsp_valid_o, bus_req_o, bus_we_o=0; fault_o=00; bus_addr_o, bus_be_o, bus_wdata_o, rdata_o=0; timeout counter=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: a request is accepted when req_valid_i and req_ready_o are both high. On acceptance, latch we, funct3, offset=addr[1:0], address and store data.
  - Illegal funct3 (011/110/111; stores also 100/101): next state RESP with fault 10. No bus activity.
  - Misaligned (H/HU with off[0]=1; W with off!=0): next state RESP with fault 01. No bus activity.
  - Otherwise: next state REQ.
- Byte enables: B = 0001<<off; H = 0011<<off; W = 1111. Loads use the same enables.
- Store data: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- REQ: bus_req_o=1. bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o stay stable until the cycle bus_gnt_i is sampled high.
  - On grant, bus_req_o deasserts next cycle.
  - Store on grant: next state RESP.
  - Load on grant: next state WAIT.
  - bus_rvalid_i in REQ is ignored.
- WAIT: when bus_rvalid_i is high, capture rdata_o = bus_rdata_i >> (8*off) (zero-filled), then go to RESP.
- RESP: rsp_valid_o=1 for exactly one cycle with rdata_o/fault_o valid, then IDLE. There is no response backpressure. req_ready_o=0 in RESP.
- Timeout: counter clears on acceptance and increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES:
  - bus_req_o drops;
  - go to RESP with fault 11 and rdata_o=0;
  - a late bus_rvalid_i in IDLE is ignored.
- Latency: zero-wait bus load (grant in the first REQ cycle, rvalid the next cycle) gives rsp_valid_o 4 cycles after the accept edge. Store gives 3 cycles. Fault gives 2 cycles.
- Reset mid-operation: all state clears asynchronously; bus_req_o drops immediately. A subsequent rvalid/gnt is ignored until a new request is accepted.
- Back-to-back requests: the next acceptance can occur in the IDLE cycle following RESP.

Decomposition:
- definitions_pkg gains:
  - lsu_state_e (IDLE/REQ/WAIT/RESP);
  - lsu_fault_e (OK/MISALIGNED/ILLEGAL/TIMEOUT);
  - funct3 load/store size localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - word_st (existing).
- One natural sub-module: lsu_lane_align, a combinational block producing byte enables, replicated store data, the misaligned/illegal flags and the load right-shift.

Test Plan:
1. LBU at addr 0x0000_1003; bus grants immediately, rvalid next cycle with 0xAABBCCDD -> bus_addr_o=0x1000, bus_be_o=1000, rdata_o=0x000000AA, fault 00, rsp 4 cycles after accept.
2. SH at 0x0000_2002 with wdata_i 0x0000_1234 -> bus_we_o=1, bus_be_o=1100, bus_wdata_o=0x12341234, rsp_valid_o 3 cycles after accept.
3. LW at 0x0000_0001 -> no bus_req_o; rsp_valid_o 2 cycles after accept, fault 01, rdata_o=0. Then funct3 011 -> fault 10.
4. Load with bus_gnt_i withheld 3 cycles -> bus_req_o, bus_addr_o and bus_be_o constant through all REQ cycles; req_ready_o=0 throughout.
5. TIMEOUT_CYCLES=8, grant given, rvalid never -> rsp_valid_o with fault 11 after 8 REQ+WAIT cycles. A later rvalid pulse in IDLE produces no response.
6. rst_ni low during WAIT, then rvalid after release -> outputs at reset values, no rsp_valid_o. Next LW at 0x10 completes normally.
